// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router. It forwards header/payload bytes to the
// selected FIFO, replays a byte stalled by a full FIFO, and checks packet parity.
// Optional macro ROUTER_REG_ERR_CNT_EN adds a saturating err_count output.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
`ifdef ROUTER_REG_ERR_CNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] int_par;
  logic [DATA_WIDTH-1:0] pkt_par;
  logic                  hold_is_par;

  logic hdr_load;
  logic par_load;
  logic par_bad;

  // Address 3 does not exist, so such a header never replaces the latched one.
  assign hdr_load = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  // Parity arrives either directly in LOAD_DATA or replayed from hold in LOAD_AFTER_FULL.
  assign par_load = ld_state ? (!pkt_valid && !fifo_full) : (laf_state && hold_is_par);
  assign par_bad  = (int_par != pkt_par);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hdr <= '0;
    end else if (hdr_load) begin
      hdr <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout        <= '0;
      hold        <= '0;
      hold_is_par <= 1'b0;
    end else if (detect_add) begin
      dout <= dout;
    end else if (lfd_state) begin
      dout <= hdr;
    end else if (ld_state) begin
      if (!fifo_full) begin
        dout <= data_in;
      end else begin
        hold        <= data_in;
        hold_is_par <= !pkt_valid;
      end
    end else if (laf_state) begin
      dout <= hold;
    end
  end

  // A stalled byte is skipped here in LOAD_DATA and folded in once when it replays.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_par <= '0;
    end else if (detect_add) begin
      int_par <= '0;
    end else if (lfd_state) begin
      int_par <= int_par ^ hdr;
    end else if (ld_state) begin
      if (pkt_valid && !full_state && !fifo_full) begin
        int_par <= int_par ^ data_in;
      end
    end else if (laf_state && !hold_is_par) begin
      int_par <= int_par ^ hold;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_par     <= '0;
      parity_done <= 1'b0;
    end else if (par_load) begin
      pkt_par     <= ld_state ? data_in : hold;
      parity_done <= 1'b1;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (rst_int_reg && parity_done) begin
      err <= par_bad;
    end else if (detect_add) begin
      err <= 1'b0;
    end
  end

`ifdef ROUTER_REG_ERR_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (rst_int_reg && parity_done && par_bad && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: drives whole packets through router_reg as the router FSM would and checks
// every output each cycle against a packet-level model (forwarded-byte queue, XOR parity).
module tb_router_reg;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  router_reg #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .resetn(resetn),
    .pkt_valid(pkt_valid),
    .data_in(data_in),
    .fifo_full(fifo_full),
    .detect_add(detect_add),
    .lfd_state(lfd_state),
    .ld_state(ld_state),
    .laf_state(laf_state),
    .full_state(full_state),
    .rst_int_reg(rst_int_reg),
    .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err(err),
    .dout(dout)
`ifdef ROUTER_REG_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: what the outputs must show after the most recent edge
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] m_dout;
  logic [7:0] m_hdr;
  logic       m_pd;
  logic       m_lpv;
  logic       m_err;
  int         m_cnt;

  logic [7:0] lfd_seen;
  logic [7:0] laf_seen;
  logic       lpv_set_seen;
  logic       lpv_clr_seen;

  int n_chk;
  int n_pass;
  bit chk_on;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("dout", dout, m_dout);
      check("parity_done", 8'(parity_done), 8'(m_pd));
      check("low_pkt_valid", 8'(low_pkt_valid), 8'(m_lpv));
      check("err", 8'(err), 8'(m_err));
`ifdef ROUTER_REG_ERR_CNT_EN
      check("err_count", err_count, 8'(m_cnt));
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic rir, input logic pv,
                       input logic [7:0] din, input logic ff);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    full_state  = fs;
    rst_int_reg = rir;
    pkt_valid   = pv;
    data_in     = din;
    fifo_full   = ff;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    resetn = 1'b0;
    m_dout = 8'h00;
    m_hdr  = 8'h00;
    m_pd   = 1'b0;
    m_lpv  = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_err", 8'(err), 8'h00);
    check("rst_parity_done", 8'(parity_done), 8'h00);
    check("rst_low_pkt_valid", 8'(low_pkt_valid), 8'h00);
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Header, payload from pay_q, parity byte. stall: index (len = parity byte) held off by
  // fifo_full for nfull FIFO_FULL cycles, -1 for none. abort: reset after that byte, -1 for none.
  task automatic send_packet(input logic [7:0] h, input logic [7:0] par, input int stall,
                             input int nfull, input int abort);
    int         len;
    logic [7:0] x;
    logic [7:0] b;
    logic       bad;
    logic       last;
    len = pay_q.size();
    drive(1, 0, 0, 0, 0, 0, 1, h, 0);
    tick();
    if (h[1:0] != 2'b11) m_hdr = h;
    m_pd  = 1'b0;
    m_err = 1'b0;
    x = m_hdr;
    foreach (pay_q[i]) x = x ^ pay_q[i];
    bad = (x != par);

    exp_q.push_back(m_hdr);
    drive(0, 1, 0, 0, 0, 0, 1, 8'($urandom), 0);
    tick();
    m_dout   = exp_q.pop_front();
    lfd_seen = dout;

    for (int i = 0; i <= len; i++) begin
      last = (i == len);
      if (last) b = par;
      else b = pay_q[i];
      exp_q.push_back(b);
      drive(0, 0, 1, 0, 0, 0, !last, b, (i == stall));
      tick();
      if (last) m_lpv = 1'b1;
      if (i == stall) begin
        for (int k = 0; k < nfull; k++) begin
          drive(0, 0, 0, 0, 1, 0, !last, 8'($urandom), 1);
          tick();
        end
        drive(0, 0, 0, 1, 0, 0, !last, 8'($urandom), 0);
        tick();
      end
      m_dout = exp_q.pop_front();
      if (i == stall) laf_seen = dout;
      if (last) begin
        m_pd = 1'b1;
        lpv_set_seen = low_pkt_valid;
      end
      if (i == abort) begin
        do_reset();
        return;
      end
    end

    drive(0, 0, 0, 0, 0, 1, 0, 8'($urandom), 0);
    tick();
    m_lpv = 1'b0;
    m_err = bad;
    if (bad && m_cnt != 255) m_cnt++;
    lpv_clr_seen = low_pkt_valid;
    drive(0, 0, 0, 0, 0, 0, 0, 8'($urandom), 0);
  endtask

  int         r_len;
  logic [7:0] r_h;
  logic [7:0] r_xp;
  logic [7:0] r_par;
  int         r_stall;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    chk_on = 1'b0;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    m_dout = 8'h00;
    m_hdr  = 8'h00;
    m_pd   = 1'b0;
    m_lpv  = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    chk_on = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0C, 8'h0C, -1, 0, -1);
    check("good_err", 8'(err), 8'h00);
    check("good_parity_done", 8'(parity_done), 8'h01);
    check("good_last_dout", dout, 8'h0C);

    send_packet(8'h0C, 8'h0D, -1, 0, -1);
    check("bad_err", 8'(err), 8'h01);
    check("bad_last_dout", dout, 8'h0D);

    send_packet(8'h0C, 8'h0C, 1, 2, -1);
    check("stall_replay_dout", laf_seen, 8'h22);
    check("stall_err", 8'(err), 8'h00);
    check("lpv_set", 8'(lpv_set_seen), 8'h01);
    check("lpv_clear", 8'(lpv_clr_seen), 8'h00);

    send_packet(8'h0F, 8'h0C, -1, 0, -1);
    check("addr3_lfd_dout", lfd_seen, 8'h0C);
    check("addr3_err", 8'(err), 8'h00);

    send_packet(8'h0C, 8'h0C, 3, 1, -1);
    check("parity_stall_replay", laf_seen, 8'h0C);
    check("parity_stall_err", 8'(err), 8'h00);

    send_packet(8'h0C, 8'h0C, -1, 0, 1);
    send_packet(8'h0C, 8'h0C, -1, 0, -1);
    check("post_reset_err", 8'(err), 8'h00);

    repeat (3) send_packet(8'h0C, 8'h0D, -1, 0, -1);
`ifdef ROUTER_REG_ERR_CNT_EN
    check("err_count_three", err_count, 8'h03);
`endif

    for (int p = 0; p < 40; p++) begin
      r_len = $urandom_range(1, 10);
      r_h   = {6'(r_len), 2'($urandom_range(0, 3))};
      pay_q.delete();
      for (int k = 0; k < r_len; k++) pay_q.push_back(8'($urandom));
      r_xp = (r_h[1:0] != 2'b11) ? r_h : m_hdr;
      foreach (pay_q[i]) r_xp = r_xp ^ pay_q[i];
      if ($urandom_range(0, 1) == 1) r_par = r_xp;
      else r_par = r_xp ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) r_stall = $urandom_range(0, r_len);
      else r_stall = -1;
      send_packet(r_h, r_par, r_stall, $urandom_range(0, 3), -1);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router, directly downstream of router_fsm.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Produces the byte stream written into the selected output FIFO (dout).
- Returns the status flags the FSM consumes: parity_done and low_pkt_valid. Also computes packet parity and flags parity errors (err).

Parameters:
- DATA_WIDTH, 8, byte width of data_in/dout; header byte layout is [DATA_WIDTH-1:2]=payload length, [1:0]=destination address.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- pkt_valid  input  1  source asserts while header/payload bytes are valid; deasserts with the parity byte
- data_in  input  DATA_WIDTH  source byte
- fifo_full  input  1  selected output FIFO is full this cycle
- detect_add  input  1  FSM in DECODE_ADDRESS
- lfd_state  input  1  FSM in LOAD_FIRST_DATA
- ld_state  input  1  FSM in LOAD_DATA
- laf_state  input  1  FSM in LOAD_AFTER_FULL
- full_state  input  1  FSM in FIFO_FULL_STATE
- rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR
- parity_done  output  1  packet parity byte has been captured
- low_pkt_valid  output  1  pkt_valid fell while in LOAD_DATA
- err  output  1  computed parity != received parity
- dout  output  DATA_WIDTH  byte presented to FIFO write port

Behaviour:
- All outputs and internal registers are reset asynchronously to 0 by resetn=0. All other updates occur on posedge clk.
- Internal registers: hdr (header byte), hold (byte stalled by full FIFO), int_par (running XOR), pkt_par (received parity byte), hold_is_par (held byte is the parity byte).
- hdr: loads data_in when detect_add && pkt_valid && data_in[1:0]!=2'b11; address 3 is never latched.
- dout, first matching rule wins:
  - lfd_state: dout<=hdr.
  - ld_state && !fifo_full: dout<=data_in.
  - ld_state && fifo_full: hold<=data_in and hold_is_par<=!pkt_valid; dout holds.
  - laf_state: dout<=hold.
  - Otherwise dout holds.
- int_par:
  - detect_add: cleared to 0.
  - lfd_state: int_par<=int_par^hdr.
  - ld_state && pkt_valid && !full_state && !fifo_full: int_par<=int_par^data_in.
  - A byte stalled by fifo_full in LOAD_DATA is XORed in laf_state, when it replays, and only if hold_is_par=0. No byte is ever XORed twice.
- pkt_par: loads data_in on ld_state && !pkt_valid && !fifo_full. In laf_state with hold_is_par=1 it loads hold.
- parity_done: set on the same edge that loads pkt_par; cleared on detect_add. Set has priority over clear if both occur in one cycle.
- low_pkt_valid: set on ld_state && !pkt_valid; cleared on rst_int_reg.
- err:
  - On rst_int_reg && parity_done: err<=(int_par!=pkt_par).
  - Cleared on detect_add.
  - Otherwise holds, so err is visible from the cycle after CHECK_PARITY_ERROR until the next header.
- Latency: data_in to dout is 1 cycle. A byte stalled by fifo_full appears on dout 1 cycle after laf_state is entered.
- Simultaneous strobes: the FSM guarantees one-hot states. If more than one strobe is high, priority is detect_add > lfd_state > ld_state > laf_state.
- Reset mid-packet: every register returns to 0 immediately; no partial parity survives.

Optional Feature:
- Macro: ROUTER_REG_ERR_CNT_EN.
- Defined: adds output err_count [7:0]. Reset 0. Increments on each edge where err is loaded with 1, saturating at 8'hFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Header 8'h0C (addr 0, len 3), payload 8'h11/8'h22/8'h33, parity 8'h0C, fifo_full=0 -> dout sequence 0C,11,22,33 one cycle after each byte; parity_done=1; err=0 after rst_int_reg.
- Same packet with parity byte 8'h0D -> parity_done=1; err=1 the cycle after rst_int_reg; err clears on next detect_add.
- fifo_full=1 while 8'h22 presented in ld_state, then full_state for 2 cycles, then laf_state -> dout=8'h22 after laf_state; int_par still 8'h0C; err=0.
- pkt_valid falls in ld_state -> low_pkt_valid=1 next edge; stays 1 until rst_int_reg, then 0.
- detect_add with data_in=8'h0F (addr 3) -> hdr unchanged; lfd_state then drives the previous hdr value.
- resetn=0 after two payload bytes -> dout, err, parity_done, low_pkt_valid = 0 immediately; new packet 8'h0C/11/22/33/0C after release -> err=0. With ROUTER_REG_ERR_CNT_EN defined, three bad-parity packets give err_count=3.
